// File: rtl/p3_pll_ctrl.sv
// p3_pll_ctrl: ProASIC3 PLL power-up/lock sequencer with staged GLA/GLB/GLC reset release.
// Define P3_PLL_CTRL_LOSS_CNT_EN to add the loss_cnt_o lock-loss counter port.
module p3_pll_ctrl #(
    parameter int PD_CYCLES    = 16,
    parameter int LOCK_TIMEOUT = 65536,
    parameter int LOCK_STABLE  = 1024,
    parameter int RST_STAGGER  = 8,
    parameter int MAX_RETRIES  = 3
) (
    input  logic       clka_i,
    input  logic       rst_i,
    input  logic       en_i,
    input  logic       lock_i,
    output logic       powerdown_o,
    output logic       rst_gla_o,
    output logic       rst_glb_o,
    output logic       rst_glc_o,
    output logic       ready_o,
    output logic       fault_o,
    output logic [1:0] retry_cnt_o,
    output logic [2:0] state_o
`ifdef P3_PLL_CTRL_LOSS_CNT_EN
    ,
    output logic [7:0] loss_cnt_o
`endif
);
    localparam int TMAX = (PD_CYCLES > 2 * RST_STAGGER) ? PD_CYCLES : 2 * RST_STAGGER;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int WW   = $clog2(LOCK_TIMEOUT + 1);
    localparam int SW   = $clog2(LOCK_STABLE + 1);

    typedef enum logic [2:0] {
        OFF       = 3'd0,
        PWRDN     = 3'd1,
        WAIT_LOCK = 3'd2,
        STABLE    = 3'd3,
        RELEASE   = 3'd4,
        RUN       = 3'd5,
        FAULT     = 3'd6
    } state_e;

    state_e        state_q, state_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [WW-1:0] wt_q, wt_d;
    logic [SW-1:0] st_q, st_d;
    logic [1:0]    retry_q, retry_d;
    logic          lock_m_q, lock_s_q;
    logic          fail;
    logic [5:0]    out_q, out_d;

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        fail    = 1'b0;
        case (state_q)
            OFF:       state_d = en_i ? PWRDN : OFF;
            PWRDN:     state_d = (tmr_q == TW'(PD_CYCLES - 1)) ? WAIT_LOCK : PWRDN;
            WAIT_LOCK: begin
                state_d = lock_s_q ? STABLE : WAIT_LOCK;
                fail    = !lock_s_q && (wt_q >= WW'(LOCK_TIMEOUT - 1));
            end
            STABLE:    state_d = !lock_s_q ? WAIT_LOCK : (st_q == SW'(LOCK_STABLE - 1)) ? RELEASE : STABLE;
            RELEASE: begin
                state_d = (tmr_q == TW'(2 * RST_STAGGER - 1)) ? RUN : RELEASE;
                fail    = !lock_s_q;
            end
            RUN:       fail = !lock_s_q;
            default:   state_d = FAULT;
        endcase
        if (fail) begin
            retry_d = (retry_q == 2'd3) ? 2'd3 : retry_q + 2'd1;
            state_d = (retry_d > 2'(MAX_RETRIES - 1)) ? FAULT : PWRDN;
        end
        if (!en_i) begin
            state_d = OFF;
            retry_d = '0;
        end
        tmr_d = (state_d == state_q) ? tmr_q + 1'b1 : '0;
        // The lock seen while leaving WAIT_LOCK already counts as the first stable cycle.
        st_d  = (state_d != STABLE) ? '0 : (state_q == STABLE) ? st_q + 1'b1 : SW'(1);
        // The lock timeout keeps its progress across STABLE bounces; only a fresh attempt clears it.
        wt_d  = (state_d != WAIT_LOCK) ? wt_q : (state_q == WAIT_LOCK) ? wt_q + 1'b1 :
                (state_q == STABLE) ? wt_q : '0;
        out_d = {state_d inside {WAIT_LOCK, STABLE, RELEASE, RUN},
                 !(state_d inside {RELEASE, RUN}),
                 !(state_d == RUN || (state_d == RELEASE && tmr_d >= TW'(RST_STAGGER))),
                 state_d != RUN,
                 state_d == RUN,
                 state_d == FAULT};
    end

    always_ff @(posedge clka_i) begin
        if (rst_i) begin
            state_q  <= OFF;
            tmr_q    <= '0;
            wt_q     <= '0;
            st_q     <= '0;
            retry_q  <= '0;
            lock_m_q <= 1'b0;
            lock_s_q <= 1'b0;
            out_q    <= 6'b011100;
        end else begin
            state_q  <= state_d;
            tmr_q    <= tmr_d;
            wt_q     <= wt_d;
            st_q     <= st_d;
            retry_q  <= retry_d;
            lock_m_q <= lock_i;
            lock_s_q <= lock_m_q;
            out_q    <= out_d;
        end
    end

    assign {powerdown_o, rst_gla_o, rst_glb_o, rst_glc_o, ready_o, fault_o} = out_q;
    assign retry_cnt_o = retry_q;
    assign state_o     = state_q;

`ifdef P3_PLL_CTRL_LOSS_CNT_EN
    logic [7:0] loss_q;

    always_ff @(posedge clka_i) begin
        if (rst_i) loss_q <= '0;
        else if (state_q == RUN && !lock_s_q && en_i && loss_q != 8'hFF) loss_q <= loss_q + 8'd1;
    end

    assign loss_cnt_o = loss_q;
`endif
endmodule

// File: tb/tb_p3_pll_ctrl.sv
// tb_p3_pll_ctrl: directed, randomly timed sequence for p3_pll_ctrl; expected latencies come
// from the sequencing rules expressed as edge counts relative to the stimulus events.
module tb_p3_pll_ctrl;
    localparam int PD = 4, TO = 40, LS = 12, S = 3, MR = 3;

    logic       clk = 1'b0, rst = 1'b1, en = 1'b0, lock = 1'b0;
    logic       powerdown, gla, glb, glc, ready, fault;
    logic [1:0] retry;
    logic [2:0] state;
`ifdef P3_PLL_CTRL_LOSS_CNT_EN
    logic [7:0] loss_cnt;
`endif
    int n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    p3_pll_ctrl #(.PD_CYCLES(PD), .LOCK_TIMEOUT(TO), .LOCK_STABLE(LS), .RST_STAGGER(S),
                  .MAX_RETRIES(MR)) dut (
        .clka_i(clk), .rst_i(rst), .en_i(en), .lock_i(lock),
        .powerdown_o(powerdown), .rst_gla_o(gla), .rst_glb_o(glb), .rst_glc_o(glc),
        .ready_o(ready), .fault_o(fault), .retry_cnt_o(retry), .state_o(state)
`ifdef P3_PLL_CTRL_LOSS_CNT_EN
        , .loss_cnt_o(loss_cnt)
`endif
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic int sig(input int sel);
        case (sel)
            0:       return int'(powerdown);
            1:       return int'(gla);
            2:       return int'(glb);
            3:       return int'(glc);
            4:       return int'(ready);
            5:       return int'(fault);
            default: return int'(retry);
        endcase
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Counts clock edges until the selected output reaches val; gives up at lim edges.
    task automatic wait_for(input int sel, input int val, input int lim, output int n);
        n = 0;
        do begin
            step(1);
            n++;
        end while (sig(sel) != val && n < lim);
    endtask

    initial begin
        int n, d, j, r;
        step(3);
        chk("reset_state", state, 0);
        chk("reset_powerdown", powerdown, 0);
        chk("reset_resets", {gla, glb, glc}, 7);
        chk("reset_ready_fault", {ready, fault}, 0);
        chk("reset_retry", retry, 0);

        rst = 1'b0;
        en  = 1'b1;
        wait_for(0, 1, 200, n);
        chk("pwrdn_length", n, PD + 1);
        chk("wait_lock_state", state, 2);
        d = $urandom_range(0, TO - 10);
        step(d);
        lock = 1'b1;
        wait_for(1, 0, 200, n);
        chk("gla_latency", n, LS + 2);
        chk("gla_only", {glb, glc, ready}, 3'b110);
        wait_for(2, 0, 50, n);
        chk("glb_stagger", n, S);
        chk("glc_held", glc, 1);
        wait_for(3, 0, 50, n);
        chk("glc_stagger", n, S);
        chk("ready_with_glc", ready, 1);
        chk("run_state", state, 5);

        step($urandom_range(1, 20));
        lock = 1'b0;
        wait_for(4, 0, 20, n);
        chk("loss_latency", n, 3);
        chk("loss_resets", {gla, glb, glc}, 7);
        chk("loss_retry", retry, 1);
        chk("loss_state", state, 1);
        chk("loss_powerdown", powerdown, 0);
`ifdef P3_PLL_CTRL_LOSS_CNT_EN
        chk("loss_cnt", loss_cnt, 1);
`endif
        wait_for(0, 1, 50, n);
        chk("repwrdn_length", n, PD);
        step($urandom_range(0, 10));
        lock = 1'b1;
        j = $urandom_range(2, LS - 3);
        step(j);
        lock = 1'b0;
        step(1);
        lock = 1'b1;
        wait_for(1, 0, 200, n);
        chk("glitch_release", n, LS + 2);
        chk("glitch_retry", retry, 1);

        r = $urandom_range(0, 2 * S - 2);
        step(r);
        en = 1'b0;
        step(1);
        chk("en0_state", state, 0);
        chk("en0_resets", {gla, glb, glc}, 7);
        chk("en0_retry", retry, 0);
        chk("en0_pd_ready", {powerdown, ready}, 0);
`ifdef P3_PLL_CTRL_LOSS_CNT_EN
        chk("loss_cnt_kept", loss_cnt, 1);
`endif
        lock = 1'b0;
        step(3);
        en = 1'b1;
        wait_for(6, 1, PD + TO + 10, n);
        chk("attempt1", n, 1 + PD + TO);
        wait_for(6, 2, PD + TO + 10, n);
        chk("attempt2", n, PD + TO);
        wait_for(5, 1, PD + TO + 10, n);
        chk("attempt3", n, PD + TO);
        chk("fault_retry", retry, 3);
        chk("fault_state", state, 6);
        chk("fault_pd_ready", {powerdown, ready}, 0);
        chk("fault_resets", {gla, glb, glc}, 7);
        step(5);
        chk("fault_hold", state, 6);

        en = 1'b0;
        step(1);
        chk("fault_off_state", state, 0);
        chk("fault_off_flag", fault, 0);
        en = 1'b1;
        step(1);
        chk("restart_state", state, 1);
        chk("restart_retry_fault", {retry, fault}, 0);
        step(2);
        rst = 1'b1;
        step(1);
        chk("rst_override", state, 0);
        rst = 1'b0;
        en  = 1'b0;
        step(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
